// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared lane commutator types, defaults and index helper
package ntt_pkg;

    localparam int LANES_DEF  = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        CM_PASS    = 2'd0,
        CM_REFLECT = 2'd1,
        CM_ROTL    = 2'd2,
        CM_ROTR    = 2'd3
    } comm_mode_e;

    // Source lane feeding output lane j; lanes is a power of 2, so masking is mod.
    function automatic logic [31:0] lane_idx(
        input logic [1:0]  mode,
        input logic [31:0] p,
        input logic [31:0] j,
        input logic [31:0] lanes
    );
        logic [31:0] raw;
        case (comm_mode_e'(mode))
            CM_REFLECT: raw = p - j;
            CM_ROTL:    raw = j + p;
            CM_ROTR:    raw = j - p;
            default:    raw = j;
        endcase
        return raw & (lanes - 32'd1);
    endfunction

endpackage

// File: rtl/commutor_perm.sv
// rtl/commutor_perm.sv - combinational per-lane mux array for the commutator
module commutor_perm
    import ntt_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]                mode,
    input  logic [$clog2(LANES)-1:0] phase,
    input  logic [LANES*DATA_W-1:0]  lane_in,
    output logic [LANES*DATA_W-1:0]  next_lane
);

    localparam int PW = $clog2(LANES);

    logic [DATA_W-1:0] in_arr [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_split
        assign in_arr[k] = lane_in[k*DATA_W +: DATA_W];
    end

    for (genvar j = 0; j < LANES; j++) begin : g_mux
        logic [PW-1:0] src;
        assign src = PW'(lane_idx(mode, 32'(phase), 32'(j), 32'(LANES)));
        assign next_lane[j*DATA_W +: DATA_W] = in_arr[src];
    end

endmodule

// File: rtl/commutor_gen.sv
// rtl/commutor_gen.sv - parametrised lane commutator with phase counter and output register
module commutor_gen
    import ntt_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int GROUP  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [1:0]                mode,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [LANES*DATA_W-1:0]  lane_in,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [LANES*DATA_W-1:0]  lane_out,
    output logic [$clog2(LANES)-1:0] phase_o,
    output logic                      wrap_o
);

    localparam int PW = $clog2(LANES);
    localparam int GW = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(LANES - 1);
    localparam logic [GW-1:0] BC_LAST = GW'(GROUP - 1);

    logic [PW-1:0]           phase;
    logic [GW-1:0]           beat_cnt;
    logic                    accept;
    logic                    group_end;
    logic [LANES*DATA_W-1:0] next_lane;

    assign ready_out = !valid_out || ready_in;
    assign accept    = valid_in && ready_out;
    assign group_end = (beat_cnt == BC_LAST);

    commutor_perm #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_perm (
        .mode      (mode),
        .phase     (phase),
        .lane_in   (lane_in),
        .next_lane (next_lane)
    );

    // clear wins over a same-cycle accept; lane_out keeps its last contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            beat_cnt  <= '0;
            valid_out <= 1'b0;
            lane_out  <= '0;
            phase_o   <= '0;
            wrap_o    <= 1'b0;
        end else if (clear) begin
            phase     <= '0;
            beat_cnt  <= '0;
            valid_out <= 1'b0;
            wrap_o    <= 1'b0;
        end else if (accept) begin
            valid_out <= 1'b1;
            lane_out  <= next_lane;
            phase_o   <= phase;
            wrap_o    <= (phase == PH_LAST) && group_end;
            if (group_end) begin
                beat_cnt <= '0;
                phase    <= phase + PW'(1);
            end else begin
                beat_cnt <= beat_cnt + GW'(1);
            end
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: doc/commutor_gen.md
Name: commutor_gen

Overview:
- Parametrised lane commutator for the streaming NTT/INTT pipeline. It sits between delay_unit stages and replaces the fixed 8-lane commutors.
- Each accepted beat is permuted across LANES lanes according to a phase counter and a runtime mode. The result is held in an output register with a valid/ready handshake.
- Beyond the fixed commutors, it adds:
  - generic lane count and data width;
  - three permutation modes plus pass-through;
  - a phase advance every GROUP beats;
  - backpressure, a frame-wrap flag and reset of every output.

Parameters:
- LANES, 8, number of lanes; must be a power of 2 and at least 2; PW = $clog2(LANES).
- DATA_W, 16, bits per lane coefficient.
- GROUP, 1, accepted beats per phase step; must be at least 1; GW = max(1, $clog2(GROUP)).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous frame restart (the nttend equivalent)
- mode  in  2  0 = pass, 1 = reflect, 2 = rotate-left, 3 = rotate-right; sampled on each accepted beat
- valid_in  in  1  upstream beat valid
- ready_out  out  1  block can accept a beat
- lane_in  in  LANES*DATA_W  input lanes; lane k occupies bits [k*DATA_W +: DATA_W]
- valid_out  out  1  output beat valid
- ready_in  in  1  downstream accepts the beat
- lane_out  out  LANES*DATA_W  permuted lanes
- phase_o  out  PW  phase used for the beat currently in lane_out
- wrap_o  out  1  lane_out holds the last beat of a frame

Behaviour:
- Reset (rst_n low, asynchronous): valid_out=0, lane_out=0, phase_o=0, wrap_o=0; internal phase=0 and beat_cnt=0.
- Handshake:
  - ready_out = !valid_out || ready_in (combinational).
  - accept = valid_in && ready_out.
  - The output register loads on accept.
  - valid_out clears when ready_in is high and there is no accept.
  - While valid_out && !ready_in, all outputs hold stable.
- Latency: 1 cycle from accept to valid_out. Full throughput of 1 beat/cycle while ready_in stays high.
- Permutation, with p = current phase and indices taken mod LANES:
  - pass: out[j] = in[j]
  - reflect: out[j] = in[(p - j)]
  - rotate-left: out[j] = in[(j + p)]
  - rotate-right: out[j] = in[(j - p)]
- Phase counter:
  - beat_cnt increments on each accept.
  - When beat_cnt = GROUP-1 on an accept, beat_cnt returns to 0 and phase increments.
  - Phase wraps from LANES-1 to 0 without any gap.
- Frame wrap: wrap_o is loaded with (phase = LANES-1 && beat_cnt = GROUP-1) on accept. A frame is LANES*GROUP beats.
- Frame output: phase_o is loaded with the phase used for that beat.
- clear:
  - Sets phase=0, beat_cnt=0, valid_out=0 and wrap_o=0 on the next edge. lane_out is left unchanged.
  - clear has priority over accept in the same cycle; that beat is dropped.
  - ready_out is unaffected by clear.
- Mode change mid-frame is legal. It affects only beats accepted from that cycle on and does not touch the phase.
- Reset mid-frame: all state returns to its reset value immediately.

Decomposition:
- Package ntt_pkg:
  - LANES_DEF and DATA_W_DEF constants;
  - enum comm_mode_e {CM_PASS, CM_REFLECT, CM_ROTL, CM_ROTR};
  - function lane_idx(mode, p, j) returning the source index mod LANES.
- Sub-module commutor_perm: purely combinational LANES-way mux array (mode, phase, lane_in -> next_lane), generated per output lane.
- The commutor_gen top holds the counters, handshake and output register.

Test Plan:
- Reflect mode, LANES=8, GROUP=1, ready_in=1, lane_in[k]=10*b+k on beat b:
  - beat 1 -> lane_out = {11,10,17,16,15,14,13,12} for lanes 0..7;
  - beat 0 -> lanes 0..7 = {0,7,6,5,4,3,2,1};
  - wrap_o=1 only on beat 7;
  - beat 8 repeats the phase-0 pattern.
- Rotate-left, LANES=4, GROUP=2:
  - beats 0,1 have phase 0 (identity);
  - beats 2,3 have phase 1, so lane_out[0]=in[1] and lane_out[3]=in[0];
  - wrap_o asserts on beat 7.
- Backpressure: hold ready_in=0 for 3 cycles with valid_out=1 -> lane_out and phase_o stay stable and ready_out=0; no beat is lost or duplicated; the phase sequence resumes correctly.
- clear asserted at beat 5 together with valid_in=1 -> beat 5 is dropped and valid_out=0; the next accepted beat uses phase 0.
- Reset mid-frame at phase 3 -> all outputs are 0 asynchronously; after release the first beat uses phase 0.
- Mode switch from reflect to rotate-right at phase 2 -> the next beat gives out[j]=in[(j-2) mod 8], and the phase continues at 2 without a gap.
